// File: rtl/bmp_pixel_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bmp_pixel_serializer
// Description : Buffers RGB pixels in a small FIFO and emits them as B,G,R
//               bytes on a ready/valid port, zero-padding each row to 4 bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module bmp_pixel_serializer #(
    parameter int WIDTH      = 8,
    parameter int COLS       = 512,
    parameter int ROWS       = 512,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_BITS  = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     r_data_in,
    input  logic [WIDTH-1:0]     g_data_in,
    input  logic [WIDTH-1:0]     b_data_in,
    input  logic                 data_in_done,
    output logic [WIDTH-1:0]     byte_data,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic [ADDR_BITS-1:0] byte_addr,
    output logic                 frame_done,
    output logic                 overflow
);

    localparam int c_PAD   = (4 - ((3 * COLS) % 4)) % 4;
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int c_ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(COLS - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(ROWS - 1);
    localparam logic [1:0]         c_PAD_LAST = (c_PAD > 0) ? 2'(c_PAD - 1) : 2'd0;
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_B    = 3'd1,
        S_G    = 3'd2,
        S_R    = 3'd3,
        S_PAD  = 3'd4
    } state_t;

    // Pixel FIFO; the head entry is the pixel currently being serialized
    logic [WIDTH-1:0]   r_fifo_r [FIFO_DEPTH];
    logic [WIDTH-1:0]   r_fifo_g [FIFO_DEPTH];
    logic [WIDTH-1:0]   r_fifo_b [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    state_t               r_state;
    logic [WIDTH-1:0]     r_byte_data;
    logic                 r_byte_valid;
    logic [ADDR_BITS-1:0] r_byte_addr;
    logic                 r_frame_done;
    logic                 r_overflow;
    logic [c_COL_W-1:0]   r_col;
    logic [c_ROW_W-1:0]   r_row;
    logic [1:0]           r_pad_cnt;

    logic                 w_full;
    logic                 w_push;
    logic                 w_hs;
    logic                 w_more;
    logic                 w_any;
    logic [c_PTR_W-1:0]   w_rd_ptr_nxt;
    logic [WIDTH-1:0]     w_head_b;
    logic [WIDTH-1:0]     w_head_g;
    logic [WIDTH-1:0]     w_head_r;
    logic [WIDTH-1:0]     w_next_b;

    state_t               w_state_nxt;
    logic [WIDTH-1:0]     w_data_nxt;
    logic                 w_valid_nxt;
    logic [ADDR_BITS-1:0] w_addr_nxt;
    logic [c_COL_W-1:0]   w_col_nxt;
    logic [c_ROW_W-1:0]   w_row_nxt;
    logic [1:0]           w_pad_nxt;
    logic                 w_fd_nxt;
    logic                 w_pop;
    logic                 w_row_end;
    logic                 w_load;

    assign w_full       = (r_count == c_CNT_FULL);
    assign w_push       = data_in_done && !w_full;
    assign w_hs         = r_byte_valid && byte_ready;
    assign w_more       = (r_count > c_CNT_ONE);
    assign w_any        = (r_count != '0);
    assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;
    assign w_head_b     = r_fifo_b[r_rd_ptr];
    assign w_head_g     = r_fifo_g[r_rd_ptr];
    assign w_head_r     = r_fifo_r[r_rd_ptr];
    assign w_next_b     = r_fifo_b[w_rd_ptr_nxt];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_r[r_wr_ptr] <= r_data_in;
            r_fifo_g[r_wr_ptr] <= g_data_in;
            r_fifo_b[r_wr_ptr] <= b_data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_byte_data;
        w_valid_nxt = r_byte_valid;
        w_addr_nxt  = r_byte_addr;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_pad_nxt   = r_pad_cnt;
        w_fd_nxt    = 1'b0;
        w_pop       = 1'b0;
        w_row_end   = 1'b0;
        w_load      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_load = 1'b1;
            end
            S_B: begin
                if (w_hs) begin
                    w_state_nxt = S_G;
                    w_data_nxt  = w_head_g;
                    w_addr_nxt  = r_byte_addr + 1'b1;
                end
            end
            S_G: begin
                if (w_hs) begin
                    w_state_nxt = S_R;
                    w_data_nxt  = w_head_r;
                    w_addr_nxt  = r_byte_addr + 1'b1;
                end
            end
            S_R: begin
                if (w_hs) begin
                    w_pop      = 1'b1;
                    w_addr_nxt = r_byte_addr + 1'b1;
                    if (r_col == c_COL_LAST) begin
                        if (c_PAD > 0) begin
                            w_state_nxt = S_PAD;
                            w_data_nxt  = '0;
                            w_pad_nxt   = 2'd0;
                        end else begin
                            w_row_end = 1'b1;
                        end
                    end else begin
                        w_col_nxt = r_col + 1'b1;
                        w_load    = 1'b1;
                    end
                end
            end
            S_PAD: begin
                if (w_hs) begin
                    w_addr_nxt = r_byte_addr + 1'b1;
                    if (r_pad_cnt == c_PAD_LAST) begin
                        w_row_end = 1'b1;
                    end else begin
                        w_pad_nxt = r_pad_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
                w_data_nxt  = '0;
            end
        endcase

        if (w_row_end) begin
            w_col_nxt = '0;
            w_load    = 1'b1;
            if (r_row == c_ROW_LAST) begin
                w_row_nxt  = '0;
                w_addr_nxt = '0;
                w_fd_nxt   = 1'b1;
            end else begin
                w_row_nxt = r_row + 1'b1;
            end
        end

        // When the current head is popped this cycle, the next pixel sits one slot behind it
        if (w_load) begin
            if (w_pop ? w_more : w_any) begin
                w_state_nxt = S_B;
                w_valid_nxt = 1'b1;
                w_data_nxt  = w_pop ? w_next_b : w_head_b;
            end else begin
                w_state_nxt = S_IDLE;
                w_valid_nxt = 1'b0;
                w_data_nxt  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_byte_data  <= '0;
            r_byte_valid <= 1'b0;
            r_byte_addr  <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
            r_col        <= '0;
            r_row        <= '0;
            r_pad_cnt    <= 2'd0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
        end else begin
            r_byte_data  <= w_data_nxt;
            r_byte_valid <= w_valid_nxt;
            r_byte_addr  <= w_addr_nxt;
            r_frame_done <= w_fd_nxt;
            r_col        <= w_col_nxt;
            r_row        <= w_row_nxt;
            r_pad_cnt    <= w_pad_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (data_in_done && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign byte_data  = r_byte_data;
    assign byte_valid = r_byte_valid;
    assign byte_addr  = r_byte_addr;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_bmp_pixel_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bmp_pixel_serializer
// Description : Scoreboard bench for bmp_pixel_serializer on three geometries.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bmp_pixel_serializer;

    typedef struct packed {
        logic        last;
        logic [19:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0][7:0]  rin, gin, bin, bd;
    logic [2:0][19:0] ba;
    logic [2:0]       done, rdy, bv, fd, ovf;

    int n_cmp = 0;
    int n_fail = 0;

    exp_t q0[$], q1[$], q2[$];
    int   m_cols[3] = '{2, 4, 5};
    int   m_rows[3] = '{1, 2, 2};
    int   m_col[3], m_row[3], m_addr[3];
    int   fd_cnt[3];
    bit   fd_pend[3], stall_prev[3];
    logic [7:0]  prev_d[3];
    logic [19:0] prev_a[3];

    bmp_pixel_serializer #(.WIDTH(8), .COLS(2), .ROWS(1), .FIFO_DEPTH(4), .ADDR_BITS(20)) u_dut0 (
        .clk(clk), .reset(reset), .r_data_in(rin[0]), .g_data_in(gin[0]), .b_data_in(bin[0]),
        .data_in_done(done[0]), .byte_data(bd[0]), .byte_valid(bv[0]), .byte_ready(rdy[0]),
        .byte_addr(ba[0]), .frame_done(fd[0]), .overflow(ovf[0]));

    bmp_pixel_serializer #(.WIDTH(8), .COLS(4), .ROWS(2), .FIFO_DEPTH(16), .ADDR_BITS(20)) u_dut1 (
        .clk(clk), .reset(reset), .r_data_in(rin[1]), .g_data_in(gin[1]), .b_data_in(bin[1]),
        .data_in_done(done[1]), .byte_data(bd[1]), .byte_valid(bv[1]), .byte_ready(rdy[1]),
        .byte_addr(ba[1]), .frame_done(fd[1]), .overflow(ovf[1]));

    bmp_pixel_serializer #(.WIDTH(8), .COLS(5), .ROWS(2), .FIFO_DEPTH(16), .ADDR_BITS(20)) u_dut2 (
        .clk(clk), .reset(reset), .r_data_in(rin[2]), .g_data_in(gin[2]), .b_data_in(bin[2]),
        .data_in_done(done[2]), .byte_data(bd[2]), .byte_valid(bv[2]), .byte_ready(rdy[2]),
        .byte_addr(ba[2]), .frame_done(fd[2]), .overflow(ovf[2]));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic l, input int a, input logic [7:0] d);
        exp_t e;
        e.last = l;
        e.addr = a[19:0];
        e.data = d;
        return e;
    endfunction

    task automatic qpush(input int k, input exp_t e);
        case (k)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qtotal();
        return q0.size() + q1.size() + q2.size();
    endfunction

    // Reference byte stream: B,G,R per pixel, zero pad at row end, address wraps at frame end
    task automatic expect_pixel(input int k, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int pad;
        bit eor, eof;
        pad = (4 - ((3 * m_cols[k]) % 4)) % 4;
        eor = (m_col[k] == m_cols[k] - 1);
        eof = eor && (m_row[k] == m_rows[k] - 1);
        qpush(k, mk(1'b0, m_addr[k],     b));
        qpush(k, mk(1'b0, m_addr[k] + 1, g));
        qpush(k, mk(eof && (pad == 0), m_addr[k] + 2, r));
        m_addr[k] += 3;
        if (eor) begin
            for (int i = 0; i < pad; i++) begin
                qpush(k, mk(eof && (i == pad - 1), m_addr[k], 8'h00));
                m_addr[k]++;
            end
            m_col[k] = 0;
            if (eof) begin
                m_row[k]  = 0;
                m_addr[k] = 0;
            end else begin
                m_row[k]++;
            end
        end else begin
            m_col[k]++;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_col[k]  = 0;
            m_row[k]  = 0;
            m_addr[k] = 0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; holds the strobe for exactly one clock edge
    task automatic send(input int k, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input bit exp);
        rin[k]  = r;
        gin[k]  = g;
        bin[k]  = b;
        done[k] = 1'b1;
        if (exp) expect_pixel(k, r, g, b);
        @(posedge clk);
        #1;
        done[k] = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (qtotal() != 0 && n < 400) begin
            tick(1);
            n++;
        end
        chk("drain_pending_bytes", qtotal(), 0);
        tick(3);
    endtask

    task automatic mon(input int k);
        exp_t e;
        bit   got;
        if (fd_pend[k] || fd[k]) chk($sformatf("frame_done_%0d", k), fd[k], fd_pend[k]);
        if (fd[k]) fd_cnt[k]++;
        fd_pend[k] = 1'b0;
        if (stall_prev[k])
            chk($sformatf("stall_hold_%0d", k), {bv[k], bd[k], ba[k]}, {1'b1, prev_d[k], prev_a[k]});
        stall_prev[k] = bv[k] && !rdy[k];
        prev_d[k] = bd[k];
        prev_a[k] = ba[k];
        if (bv[k] && rdy[k]) begin
            got = 1'b0;
            case (k)
                0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
                1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
                default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
            endcase
            if (!got) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_byte_%0d: got data %0h addr %0d expected no byte", k, bd[k], ba[k]);
            end else begin
                chk($sformatf("byte_data_%0d@%0d", k, e.addr), bd[k], e.data);
                chk($sformatf("byte_addr_%0d", k), ba[k], e.addr);
                fd_pend[k] = e.last;
            end
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int k = 0; k < 3; k++) begin
                fd_pend[k]    = 1'b0;
                stall_prev[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 3; k++) mon(k);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [7:0] t1_bytes [8] = '{8'h33, 8'h22, 8'h11, 8'h66, 8'h55, 8'h44, 8'h00, 8'h00};

    initial begin
        rin = '0; gin = '0; bin = '0; done = '0; rdy = 3'b111;
        model_reset();
        for (int k = 0; k < 3; k++) fd_cnt[k] = 0;
        tick(3);
        for (int k = 0; k < 3; k++)
            chk($sformatf("reset_outputs_%0d", k), {bd[k], bv[k], ba[k], fd[k], ovf[k]}, 0);
        reset = 1'b0;
        tick(1);

        // T1: two pixels, one 8-byte frame
        for (int i = 0; i < 8; i++) qpush(0, mk(i == 7, i, t1_bytes[i]));
        send(0, 8'h11, 8'h22, 8'h33, 1'b0);
        chk("t1_valid_before_latency", bv[0], 1'b0);
        send(0, 8'h44, 8'h55, 8'h66, 1'b0);
        chk("t1_first_b_byte", {bv[0], bd[0], ba[0]}, {1'b1, 8'h33, 20'd0});
        drain();

        // T2: stall downstream while byte at addr 1 is presented
        send(0, 8'h11, 8'h22, 8'h33, 1'b1);
        send(0, 8'h44, 8'h55, 8'h66, 1'b1);
        tick(1);
        rdy[0] = 1'b0;
        chk("t2_stall_enter", {bv[0], bd[0], ba[0]}, {1'b1, 8'h22, 20'd1});
        tick(5);
        chk("t2_stall_end", {bv[0], bd[0], ba[0]}, {1'b1, 8'h22, 20'd1});
        rdy[0] = 1'b1;
        drain();

        // T4: overflow on a depth-4 FIFO with downstream blocked
        rdy[0] = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            send(0, 8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i), i <= 4);
            if (i == 4) chk("t4_overflow_before", ovf[0], 1'b0);
        end
        chk("t4_overflow_set", ovf[0], 1'b1);
        rdy[0] = 1'b1;
        drain();
        chk("t4_overflow_sticky", ovf[0], 1'b1);

        // T5: reset after three bytes of a frame
        qpush(0, mk(1'b0, 0, 8'h53));
        qpush(0, mk(1'b0, 1, 8'h52));
        qpush(0, mk(1'b0, 2, 8'h51));
        send(0, 8'h51, 8'h52, 8'h53, 1'b0);
        send(0, 8'h54, 8'h55, 8'h56, 1'b0);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("t5_outputs_after_reset", {bd[0], bv[0], ba[0], fd[0], ovf[0]}, 0);
        chk("t5_bytes_before_reset", q0.size(), 0);
        q0.delete();
        model_reset();
        send(0, 8'h61, 8'h62, 8'h63, 1'b1);
        chk("t5_valid_before_latency", bv[0], 1'b0);
        tick(1);
        chk("t5_restart_b_byte", {bv[0], bd[0], ba[0]}, {1'b1, 8'h63, 20'd0});
        send(0, 8'h64, 8'h65, 8'h66, 1'b1);
        drain();

        // T3: 4x2 frame, no padding, pixels back-to-back
        for (int i = 0; i < 8; i++)
            send(1, 8'(i + 1), 8'(8'h11 + i), 8'(8'h21 + i), 1'b1);
        drain();

        // T6: two 5x2 frames, one pad byte per row
        for (int i = 0; i < 20; i++) begin
            send(2, 8'(i + 1), 8'(8'h40 + i), 8'(8'h80 + i), 1'b1);
            tick(2);
        end
        drain();
        chk("t6_no_overflow", ovf[2], 1'b0);

        chk("frames_dut0", fd_cnt[0], 5);
        chk("frames_dut1", fd_cnt[1], 1);
        chk("frames_dut2", fd_cnt[2], 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
